// File: rtl/blk_alloc_ctrl.sv
// Block allocator: turns a request length into a stream of single-block allocations taken
// from a free-block bitmap. Optional duplicate-candidate guard under BLK_ALLOC_DUP_CHK_EN.
module blk_alloc_ctrl #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LEN_W  = 6,
    parameter int unsigned HOLD   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_vld,
    input  logic [LEN_W-1:0]  req_len,
    output logic              req_rdy,
    input  logic [ADDR_W-1:0] bm_addr,
    input  logic              bm_vld,
    input  logic [ADDR_W:0]   bm_num,
    output logic              mark_en,
    output logic [ADDR_W-1:0] mark_addr,
    output logic              mark_val,
    output logic              blk_vld,
    output logic [ADDR_W-1:0] blk_addr,
    output logic              blk_last,
    input  logic              blk_rdy,
    output logic              busy,
    output logic              err_dup
);

    localparam int unsigned CW = (ADDR_W + 1 > LEN_W) ? ADDR_W + 1 : LEN_W;
    localparam logic [2:0] HoldVal = 3'(HOLD);

    typedef enum logic [1:0] {StIdle, StCheck, StAlloc, StDrain} state_e;

    state_e state_q, state_d;

    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [2:0]        hold_cnt_q, hold_cnt_d;
    logic              mark_en_q, mark_en_d;
    logic [ADDR_W-1:0] mark_addr_q, mark_addr_d;
    logic              blk_vld_q, blk_vld_d;
    logic [ADDR_W-1:0] blk_addr_q, blk_addr_d;
    logic              blk_last_q, blk_last_d;

    logic cand_vld;
    logic issue;
    logic accept;
    logic start;
    logic rem_is_one;
    logic enough_free;

    assign accept      = blk_vld_q && blk_rdy;
    assign start       = (state_q == StIdle) && req_vld && (req_len != '0);
    assign rem_is_one  = (remaining_q == LEN_W'(1));
    assign enough_free = CW'(bm_num) >= CW'(remaining_q);
    assign issue       = (state_q == StAlloc) && cand_vld && (hold_cnt_q == '0)
                         && (!blk_vld_q || blk_rdy);

`ifdef BLK_ALLOC_DUP_CHK_EN
    logic [ADDR_W-1:0] last_addr_q;
    logic              last_vld_q;
    logic              err_dup_q;
    logic              dup_hit;

    // A candidate equal to the last issued address means the bitmap failed to mark it used.
    assign dup_hit  = last_vld_q && (bm_addr == last_addr_q);
    assign cand_vld = bm_vld && !dup_hit;
    assign err_dup  = err_dup_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_addr_q <= '0;
            last_vld_q  <= 1'b0;
            err_dup_q   <= 1'b0;
        end else begin
            if (issue) begin
                last_addr_q <= bm_addr;
                last_vld_q  <= 1'b1;
            end
            if ((state_q == StAlloc) && bm_vld && dup_hit && (hold_cnt_q == '0)) begin
                err_dup_q <= 1'b1;
            end
        end
    end
`else
    assign cand_vld = bm_vld;
    assign err_dup  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StCheck;
            StCheck: if (enough_free) state_d = StAlloc;
            StAlloc: if (issue && rem_is_one) state_d = StDrain;
            StDrain: if (accept) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_rdy = (state_q == StIdle);
        busy    = (state_q != StIdle);
    end

    always_comb begin
        remaining_d = remaining_q;
        hold_cnt_d  = hold_cnt_q;
        mark_en_d   = issue;
        mark_addr_d = mark_addr_q;
        blk_vld_d   = blk_vld_q;
        blk_addr_d  = blk_addr_q;
        blk_last_d  = blk_last_q;

        if (start) begin
            remaining_d = req_len;
        end else if (issue) begin
            remaining_d = remaining_q - LEN_W'(1);
        end

        // Hold-off lets the bitmap absorb the mark before its next candidate is trusted.
        if (issue) begin
            hold_cnt_d = HoldVal;
        end else if (hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - 3'd1;
        end

        if (issue) begin
            mark_addr_d = bm_addr;
            blk_vld_d   = 1'b1;
            blk_addr_d  = bm_addr;
            blk_last_d  = rem_is_one;
        end else if (accept) begin
            blk_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining_q <= '0;
            hold_cnt_q  <= '0;
            mark_en_q   <= 1'b0;
            mark_addr_q <= '0;
            blk_vld_q   <= 1'b0;
            blk_addr_q  <= '0;
            blk_last_q  <= 1'b0;
        end else begin
            remaining_q <= remaining_d;
            hold_cnt_q  <= hold_cnt_d;
            mark_en_q   <= mark_en_d;
            mark_addr_q <= mark_addr_d;
            blk_vld_q   <= blk_vld_d;
            blk_addr_q  <= blk_addr_d;
            blk_last_q  <= blk_last_d;
        end
    end

    assign mark_en   = mark_en_q;
    assign mark_addr = mark_addr_q;
    assign mark_val  = 1'b1;
    assign blk_vld   = blk_vld_q;
    assign blk_addr  = blk_addr_q;
    assign blk_last  = blk_last_q;

endmodule

// File: tb/tb_blk_alloc_ctrl.sv
// Directed bench for blk_alloc_ctrl: a cycle-vector table for the basic request flow plus
// hand-written sequences for back-pressure, bitmap stall, reset and duplicate handling.
module tb_blk_alloc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_vld;
    logic [5:0] req_len;
    logic       req_rdy;
    logic [9:0] bm_addr;
    logic       bm_vld;
    logic [10:0] bm_num;
    logic       mark_en;
    logic [9:0] mark_addr;
    logic       mark_val;
    logic       blk_vld;
    logic [9:0] blk_addr;
    logic       blk_last;
    logic       blk_rdy;
    logic       busy;
    logic       err_dup;

    int n_cmp  = 0;
    int n_fail = 0;
    logic follow = 1'b0;

    blk_alloc_ctrl #(.ADDR_W(10), .LEN_W(6), .HOLD(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_vld  (req_vld),
        .req_len  (req_len),
        .req_rdy  (req_rdy),
        .bm_addr  (bm_addr),
        .bm_vld   (bm_vld),
        .bm_num   (bm_num),
        .mark_en  (mark_en),
        .mark_addr(mark_addr),
        .mark_val (mark_val),
        .blk_vld  (blk_vld),
        .blk_addr (blk_addr),
        .blk_last (blk_last),
        .blk_rdy  (blk_rdy),
        .busy     (busy),
        .err_dup  (err_dup)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       req_vld;
        logic [5:0] req_len;
        logic [9:0] bm_addr;
        logic       blk_rdy;
        logic       busy;
        logic       mark_en;
        logic       blk_vld;
        logic       blk_last;
        logic [9:0] addr;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock; the simple bitmap model advances its lowest free address as marks land.
    task automatic tick();
        @(posedge clk);
        #1;
        if (follow && mark_en) bm_addr = mark_addr + 10'd1;
    endtask

    task automatic send_req(input logic [5:0] len);
        check("req_rdy_before_req", 32'(req_rdy), 32'd1);
        req_vld = 1'b1;
        req_len = len;
        tick();
        req_vld = 1'b0;
        req_len = '0;
    endtask

    task automatic expect_issue(input logic [9:0] addr, input logic last, input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!mark_en && n < 20);
        check({name, "_issued"}, 32'(mark_en), 32'd1);
        check({name, "_mark_addr"}, 32'(mark_addr), 32'(addr));
        check({name, "_blk_vld"}, 32'(blk_vld), 32'd1);
        check({name, "_blk_addr"}, 32'(blk_addr), 32'(addr));
        check({name, "_blk_last"}, 32'(blk_last), 32'(last));
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        check({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_req_rdy"}, 32'(req_rdy), 32'd1);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_mark_en"}, 32'(mark_en), 32'd0);
        check({name, "_mark_addr"}, 32'(mark_addr), 32'd0);
        check({name, "_blk_vld"}, 32'(blk_vld), 32'd0);
        check({name, "_blk_addr"}, 32'(blk_addr), 32'd0);
        check({name, "_blk_last"}, 32'(blk_last), 32'd0);
        check({name, "_err_dup"}, 32'(err_dup), 32'd0);
        check({name, "_mark_val"}, 32'(mark_val), 32'd1);
    endtask

    initial begin
        int marks;
        // req_vld, len, bm_addr, blk_rdy | busy, mark_en, blk_vld, blk_last, addr
        vecs[0]  = '{1'b1, 6'd3, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0};
        vecs[1]  = '{1'b0, 6'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0};
        vecs[2]  = '{1'b0, 6'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0};
        vecs[3]  = '{1'b0, 6'd0, 10'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0};
        vecs[4]  = '{1'b0, 6'd0, 10'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0};
        vecs[5]  = '{1'b0, 6'd0, 10'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0};
        vecs[6]  = '{1'b0, 6'd0, 10'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'd1};
        vecs[7]  = '{1'b0, 6'd0, 10'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0};
        vecs[8]  = '{1'b0, 6'd0, 10'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0};
        vecs[9]  = '{1'b0, 6'd0, 10'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0};
        vecs[10] = '{1'b0, 6'd0, 10'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10'd2};
        vecs[11] = '{1'b0, 6'd0, 10'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0};
        vecs[12] = '{1'b0, 6'd0, 10'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0};
        vecs[13] = '{1'b1, 6'd0, 10'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0};
        vecs[14] = '{1'b0, 6'd0, 10'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0};

        rst     = 1'b1;
        req_vld = 1'b0;
        req_len = '0;
        bm_addr = '0;
        bm_vld  = 1'b1;
        bm_num  = 11'd1024;
        blk_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Basic 3-block request followed by a zero-length request.
        for (int i = 0; i < 15; i++) begin
            req_vld = vecs[i].req_vld;
            req_len = vecs[i].req_len;
            bm_addr = vecs[i].bm_addr;
            blk_rdy = vecs[i].blk_rdy;
            tick();
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
            check($sformatf("vec%0d_mark_en", i), 32'(mark_en), 32'(vecs[i].mark_en));
            check($sformatf("vec%0d_blk_vld", i), 32'(blk_vld), 32'(vecs[i].blk_vld));
            if (vecs[i].mark_en)
                check($sformatf("vec%0d_mark_addr", i), 32'(mark_addr), 32'(vecs[i].addr));
            if (vecs[i].blk_vld) begin
                check($sformatf("vec%0d_blk_addr", i), 32'(blk_addr), 32'(vecs[i].addr));
                check($sformatf("vec%0d_blk_last", i), 32'(blk_last), 32'(vecs[i].blk_last));
            end
        end
        req_vld = 1'b0;
        follow  = 1'b1;

        // Not enough free blocks: wait in CHECK until the count rises.
        bm_num = 11'd2;
        send_req(6'd4);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("starved_busy", 32'(busy), 32'd1);
            check("starved_no_mark", 32'(mark_en), 32'd0);
            check("starved_req_rdy", 32'(req_rdy), 32'd0);
        end
        bm_num = 11'd4;
        expect_issue(10'd3, 1'b0, "starved_b0");
        expect_issue(10'd4, 1'b0, "starved_b1");
        expect_issue(10'd5, 1'b0, "starved_b2");
        expect_issue(10'd6, 1'b1, "starved_b3");
        wait_idle("starved");
        bm_num = 11'd1024;

        // Downstream back-pressure holds the first block and blocks the second issue.
        blk_rdy = 1'b0;
        send_req(6'd2);
        expect_issue(10'd7, 1'b0, "bp_b0");
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_held_vld", 32'(blk_vld), 32'd1);
            check("bp_held_addr", 32'(blk_addr), 32'd7);
            check("bp_held_last", 32'(blk_last), 32'd0);
            check("bp_no_mark", 32'(mark_en), 32'd0);
        end
        blk_rdy = 1'b1;
        tick();
        check("bp_b1_mark", 32'(mark_en), 32'd1);
        check("bp_b1_mark_addr", 32'(mark_addr), 32'd8);
        check("bp_b1_blk_vld", 32'(blk_vld), 32'd1);
        check("bp_b1_blk_addr", 32'(blk_addr), 32'd8);
        check("bp_b1_blk_last", 32'(blk_last), 32'd1);
        tick();
        check("bp_done_busy", 32'(busy), 32'd0);
        check("bp_done_blk_vld", 32'(blk_vld), 32'd0);

        // Reset in the middle of a request, then a fresh request against the reset bitmap.
        send_req(6'd3);
        expect_issue(10'd9, 1'b0, "rst_b0");
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst_async");
        tick();
        check_reset_outputs("mid_rst_cycle");
        rst     = 1'b0;
        bm_addr = 10'd0;
        send_req(6'd1);
        expect_issue(10'd0, 1'b1, "post_rst");
        wait_idle("post_rst");

        // Bitmap keeps presenting an already-issued address.
        follow  = 1'b0;
        bm_addr = 10'd5;
        send_req(6'd2);
        expect_issue(10'd5, 1'b0, "dup_b0");
`ifdef BLK_ALLOC_DUP_CHK_EN
        marks = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mark_en) marks++;
        end
        check("dup_no_reissue", 32'(marks), 32'd0);
        check("dup_err_set", 32'(err_dup), 32'd1);
        check("dup_still_busy", 32'(busy), 32'd1);
        bm_addr = 10'd6;
        expect_issue(10'd6, 1'b1, "dup_b1");
        wait_idle("dup");
        check("dup_err_sticky", 32'(err_dup), 32'd1);
`else
        marks = 0;
        expect_issue(10'd5, 1'b1, "dup_reissue");
        check("dup_err_clear", 32'(err_dup), 32'd0);
        wait_idle("dup");
        check("dup_err_clear_end", 32'(err_dup), 32'(marks));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
